daylight_dimmer_ctrl: RTL and testbench



---
 rtl/daylight_dimmer_ctrl.sv | 136 +++++++++++++
 tb/tb_daylight_dimmer_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/daylight_dimmer_ctrl.sv
// Daylight sensor debounce, day/night brightness ramp scheduler and PWM display enable.
// Drives the stable day flag for WARN/LED and gates the segment/diode drivers.
module daylight_dimmer_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned RAMP_TICKS      = 50000,
  parameter int unsigned PWM_BITS        = 8,
  parameter int unsigned DAY_LEVEL       = 255,
  parameter int unsigned NIGHT_LEVEL     = 32
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic                DAYLIGHT,
  output logic                DAY_STABLE,
  output logic [PWM_BITS-1:0] LEVEL,
  output logic                PWM_EN,
  output logic                RAMPING,
  output logic [1:0]          STATE
);

  localparam logic [1:0] ST_NIGHT     = 2'd0;
  localparam logic [1:0] ST_RAMP_UP   = 2'd1;
  localparam logic [1:0] ST_DAY       = 2'd2;
  localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned RW = $clog2(RAMP_TICKS) + 1;
  localparam logic [DW-1:0]       LP_DEB_TC  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0]       LP_RAMP_TC = RW'(RAMP_TICKS - 1);
  localparam logic [PWM_BITS-1:0] LP_DAY     = PWM_BITS'(DAY_LEVEL);
  localparam logic [PWM_BITS-1:0] LP_NIGHT   = PWM_BITS'(NIGHT_LEVEL);

  logic [1:0]          r_sync;
  logic [DW-1:0]       r_deb_cnt;
  logic                r_day;
  logic [1:0]          r_state;
  logic [PWM_BITS-1:0] r_level;
  logic [RW-1:0]       r_presc;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] r_shadow;
  logic                r_pwm_en;
  logic                w_s;
  logic                w_tick;

  assign w_s    = r_sync[1];
  assign w_tick = (r_presc == LP_RAMP_TC);

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_sync    <= '0;
      r_deb_cnt <= '0;
      r_day     <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], DAYLIGHT};
      if (w_s == r_day) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == LP_DEB_TC) begin
        r_day     <= w_s;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end
  end

  // Setpoint check precedes the step, so LEVEL stays inside [NIGHT, DAY].
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_state <= ST_NIGHT;
      r_level <= LP_NIGHT;
      r_presc <= '0;
    end else begin
      case (r_state)
        ST_NIGHT: begin
          r_presc <= '0;
          if (r_day) r_state <= ST_RAMP_UP;
        end
        ST_RAMP_UP: begin
          if (!r_day) begin
            r_state <= ST_RAMP_DOWN;
            r_presc <= '0;
          end else if (r_level == LP_DAY) begin
            r_state <= ST_DAY;
            r_presc <= '0;
          end else if (w_tick) begin
            r_level <= r_level + 1'b1;
            r_presc <= '0;
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
        ST_DAY: begin
          r_presc <= '0;
          if (!r_day) r_state <= ST_RAMP_DOWN;
        end
        ST_RAMP_DOWN: begin
          if (r_day) begin
            r_state <= ST_RAMP_UP;
            r_presc <= '0;
          end else if (r_level == LP_NIGHT) begin
            r_state <= ST_NIGHT;
            r_presc <= '0;
          end else if (w_tick) begin
            r_level <= r_level - 1'b1;
            r_presc <= '0;
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
        default: begin
          r_state <= ST_NIGHT;
          r_presc <= '0;
        end
      endcase
    end
  end

  // Shadow level reloads only at the period boundary to keep PWM glitch-free.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_pwm_cnt <= '0;
      r_shadow  <= '0;
      r_pwm_en  <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (r_pwm_cnt == '1) r_shadow <= r_level;
      r_pwm_en <= (r_pwm_cnt < r_shadow);
    end
  end

  assign DAY_STABLE = r_day;
  assign LEVEL      = r_level;
  assign PWM_EN     = r_pwm_en;
  assign STATE      = r_state;
  assign RAMPING    = r_state[0];

endmodule

// File: tb/tb_daylight_dimmer_ctrl.sv
// Randomized scoreboard bench for daylight_dimmer_ctrl against a cycle-level behavioural model.
module tb_daylight_dimmer_ctrl;

  localparam int DEB = 8;
  localparam int RT  = 4;
  localparam int PB  = 4;
  localparam int DL  = 12;
  localparam int NL  = 3;
  localparam int PER = 1 << PB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          din = 1'b0;
  logic          day_stable;
  logic [PB-1:0] level;
  logic          pwm_en;
  logic          ramping;
  logic [1:0]    state;

  daylight_dimmer_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .RAMP_TICKS(RT),
    .PWM_BITS(PB),
    .DAY_LEVEL(DL),
    .NIGHT_LEVEL(NL)
  ) dut (
    .CLOCK_50(clk),
    .RESET(rst),
    .DAYLIGHT(din),
    .DAY_STABLE(day_stable),
    .LEVEL(level),
    .PWM_EN(pwm_en),
    .RAMPING(ramping),
    .STATE(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int day;
    int lvl;
    int st;
    int rmp;
    int pwm;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  bit stim_done = 0;

  // Behavioural model: history of samples, run-length debounce, mode/level/ticks, period-based PWM.
  int m_hist[2];
  int m_day, m_run, m_mode, m_lvl, m_ticks, m_phase, m_duty, m_pwm;

  task automatic model_edge(input int r, input int d);
    int s, od, nd;
    if (r != 0) begin
      m_hist[0] = 0; m_hist[1] = 0;
      m_day = 0; m_run = 0; m_mode = 0; m_lvl = NL; m_ticks = 0;
      m_phase = 0; m_duty = 0; m_pwm = 0;
      return;
    end
    s  = m_hist[1];
    od = m_day;
    nd = m_day;
    if (s != od) begin
      m_run++;
      if (m_run == DEB) begin nd = s; m_run = 0; end
    end else begin
      m_run = 0;
    end
    m_pwm = (m_phase < m_duty) ? 1 : 0;
    if (m_phase == PER - 1) m_duty = m_lvl;
    m_phase = (m_phase + 1) % PER;
    case (m_mode)
      0: if (od == 1) begin m_mode = 1; m_ticks = 0; end
      2: if (od == 0) begin m_mode = 3; m_ticks = 0; end
      1: begin
        if (od == 0) begin m_mode = 3; m_ticks = 0; end
        else if (m_lvl == DL) m_mode = 2;
        else begin
          m_ticks++;
          if (m_ticks == RT) begin m_lvl++; m_ticks = 0; end
        end
      end
      default: begin
        if (od == 1) begin m_mode = 1; m_ticks = 0; end
        else if (m_lvl == NL) m_mode = 0;
        else begin
          m_ticks++;
          if (m_ticks == RT) begin m_lvl--; m_ticks = 0; end
        end
      end
    endcase
    m_day = nd;
    m_hist[1] = m_hist[0];
    m_hist[0] = d;
  endtask

  task automatic apply(input bit r, input bit d, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      rst = r;
      din = d;
      model_edge(int'(r), int'(d));
      e.day = m_day;
      e.lvl = m_lvl;
      e.st  = m_mode;
      e.rmp = (m_mode == 1 || m_mode == 3) ? 1 : 0;
      e.pwm = m_pwm;
      q.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  initial begin : stim
    bit d;
    int sel;
    apply(1, 1, 3);
    apply(0, 1, 60);
    apply(0, 0, 70);
    apply(0, 1, 6);
    apply(0, 0, 20);
    apply(0, 1, 27);
    apply(0, 0, 60);
    apply(0, 1, 32);
    apply(1, 1, 1);
    apply(0, 1, 5);
    apply(1, 0, 2);
    apply(0, 1, 80);
    d = 1'b1;
    for (int k = 0; k < 60; k++) begin
      sel = int'($urandom_range(0, 19));
      if (sel == 0) begin
        apply(1, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
      end else begin
        if ($urandom_range(0, 3) != 0) d = ~d;
        apply(0, d, int'($urandom_range(1, 60)));
      end
    end
    stim_done = 1;
  end

  initial begin : monitor
    exp_t e;
    int cycles = 0;
    while (!(stim_done && q.size() == 0)) begin
      @(posedge clk);
      #2;
      cycles++;
      if (cycles > 50000) begin
        check("cycle_budget", cycles, 50000);
        break;
      end
      if (q.size() == 0) begin
        if (!stim_done) check("queue_underflow", 0, 1);
        continue;
      end
      e = q.pop_front();
      check("DAY_STABLE", int'(day_stable), e.day);
      check("LEVEL", int'(level), e.lvl);
      check("STATE", int'(state), e.st);
      check("RAMPING", int'(ramping), e.rmp);
      check("PWM_EN", int'(pwm_en), e.pwm);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
